// File: rtl/instruction_fetch.sv
// instruction_fetch: prefetch stage that fills a small byte FIFO from memory ahead of the decoder
//   clk, rst_n            clock, asynchronous active-low reset
//   redirect_i/_addr_i    branch taken: flush FIFO and restart fetching at the target
//   consume_i             decoder takes the head byte
//   mem_req_o/_addr_o     memory read request and address (held until mem_ack_i)
//   mem_ack_i/_data_i     read completion and data
//   instruction_o         head byte (NOP_BYTE when empty), head_pc_o its address
//   normal_o              head byte valid, flush_o one-cycle pulse after a redirect
`timescale 1ns/1ps
module instruction_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  NOP_BYTE = 8'hEA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [15:0] redirect_addr_i,
  input  logic        consume_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  instruction_o,
  output logic [15:0] head_pc_o,
  output logic        normal_o,
  output logic        flush_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d, stale_q, stale_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic          req_q, flush_q;
  logic [7:0]    fifo_q [DEPTH];
  logic          ack, push, pop;
  // an ack only counts while a request is actually driven (not in the cycle after reset)
  assign ack  = mem_ack_i & req_q;
  assign push = ack & (state_q == REQ) & ~redirect_i;
  assign pop  = consume_i & (count_q != '0) & ~redirect_i;
  always_comb begin
    count_d = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
    pc_d    = redirect_i ? redirect_addr_i : push ? pc_q + 16'd1 : pc_q;
    rd_d    = redirect_i ? '0 : rd_q + AW'(pop);
    wr_d    = redirect_i ? '0 : wr_q + AW'(push);
    // track the open request address so DISCARD keeps presenting it after pc moves
    stale_d = (state_q == REQ) ? pc_q : stale_q;
    state_d = state_q;
    if (redirect_i)
      state_d = (req_q & ~mem_ack_i) ? DISCARD : REQ;
    else if (state_q == IDLE)
      state_d = (count_q < CW'(DEPTH)) ? REQ : IDLE;
    else if (ack)
      state_d = (state_q == DISCARD || count_d < CW'(DEPTH)) ? REQ : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      stale_q <= RESET_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      req_q   <= (state_d != IDLE);
      flush_q <= redirect_i;
    end
  end
  always_ff @(posedge clk)
    if (push) fifo_q[wr_q] <= mem_data_i;
  assign mem_req_o     = req_q;
  assign mem_addr_o    = (state_q == DISCARD) ? stale_q : pc_q;
  assign normal_o      = (count_q != '0);
  assign instruction_o = normal_o ? fifo_q[rd_q] : NOP_BYTE;
  assign head_pc_o     = pc_q - 16'(count_q);
  assign flush_o       = flush_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector bench for instruction_fetch
`timescale 1ns/1ps
module tb_instruction_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        redirect = 1'b0, consume = 1'b0, mem_ack = 1'b0;
  logic [15:0] redirect_addr = 16'h0;
  logic [7:0]  mem_data = 8'h0;
  logic        mem_req, normal, flush;
  logic [15:0] mem_addr, head_pc;
  logic [7:0]  instruction;
  int checks = 0, errors = 0;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .consume_i(consume), .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .mem_data_i(mem_data), .instruction_o(instruction), .head_pc_o(head_pc),
    .normal_o(normal), .flush_o(flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [15:0] ra;
    logic        cn;
    logic        ak;
    logic [7:0]  dt;
    logic        e_req;
    logic [15:0] e_addr;
    logic [7:0]  e_ins;
    logic [15:0] e_head;
    logic        e_nrm;
    logic        e_fl;
  } vec_t;

  localparam int NV = 24;
  vec_t v [NV];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic e_req, input logic [15:0] e_addr,
                         input logic [7:0] e_ins, input logic [15:0] e_head,
                         input logic e_nrm, input logic e_fl);
    chk("mem_req", idx, {15'h0, mem_req}, {15'h0, e_req});
    chk("mem_addr", idx, mem_addr, e_addr);
    chk("instruction", idx, {8'h0, instruction}, {8'h0, e_ins});
    chk("head_pc", idx, head_pc, e_head);
    chk("normal", idx, {15'h0, normal}, {15'h0, e_nrm});
    chk("flush", idx, {15'h0, flush}, {15'h0, e_fl});
  endtask

  initial begin
    //        rd  ra        cn ak dt     req addr      ins    head      nrm fl
    v[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hA9, 1'b1, 16'h0000, 8'hEA, 16'h0000, 1'b0, 1'b0};
    v[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hA9, 1'b1, 16'h0001, 8'hA9, 16'h0000, 1'b1, 1'b0};
    v[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h05, 1'b1, 16'h0002, 8'hA9, 16'h0000, 1'b1, 1'b0};
    v[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h11, 1'b1, 16'h0003, 8'hA9, 16'h0000, 1'b1, 1'b0};
    v[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h22, 1'b0, 16'h0004, 8'hA9, 16'h0000, 1'b1, 1'b0};
    v[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h33, 1'b0, 16'h0004, 8'hA9, 16'h0000, 1'b1, 1'b0};
    v[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0004, 8'h05, 16'h0001, 1'b1, 1'b0};
    v[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0004, 8'h05, 16'h0001, 1'b1, 1'b0};
    v[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h44, 1'b1, 16'h0005, 8'h11, 16'h0002, 1'b1, 1'b0};
    v[9]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0005, 8'hEA, 16'h1234, 1'b0, 1'b1};
    v[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0005, 8'hEA, 16'h1234, 1'b0, 1'b0};
    v[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h99, 1'b1, 16'h1234, 8'hEA, 16'h1234, 1'b0, 1'b0};
    v[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h5A, 1'b1, 16'h1235, 8'h5A, 16'h1234, 1'b1, 1'b0};
    v[13] = '{1'b1, 16'h2000, 1'b1, 1'b1, 8'h77, 1'b1, 16'h2000, 8'hEA, 16'h2000, 1'b0, 1'b1};
    v[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 16'h2000, 8'hEA, 16'h2000, 1'b0, 1'b0};
    v[15] = '{1'b1, 16'hFFFE, 1'b0, 1'b0, 8'h00, 1'b1, 16'h2000, 8'hEA, 16'hFFFE, 1'b0, 1'b1};
    v[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h01, 1'b1, 16'hFFFE, 8'hEA, 16'hFFFE, 1'b0, 1'b0};
    v[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h02, 1'b1, 16'hFFFF, 8'h02, 16'hFFFE, 1'b1, 1'b0};
    v[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h03, 1'b1, 16'h0000, 8'h02, 16'hFFFE, 1'b1, 1'b0};
    v[19] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h04, 1'b1, 16'h0001, 8'h02, 16'hFFFE, 1'b1, 1'b0};
    v[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0001, 8'h03, 16'hFFFF, 1'b1, 1'b0};
    v[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0001, 8'h04, 16'h0000, 1'b1, 1'b0};
    v[22] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0001, 8'hEA, 16'h0001, 1'b0, 1'b0};
    v[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0001, 8'hEA, 16'h0001, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 1'b0, 16'h0000, 8'hEA, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      redirect      = v[i].rd;
      redirect_addr = v[i].ra;
      consume       = v[i].cn;
      mem_ack       = v[i].ak;
      mem_data      = v[i].dt;
      @(posedge clk);
      #1;
      chk_all(i, v[i].e_req, v[i].e_addr, v[i].e_ins, v[i].e_head, v[i].e_nrm, v[i].e_fl);
    end

    // open a redirect so flush is high and a byte sits in the FIFO, then reset between edges
    redirect = 1'b0; consume = 1'b0; mem_ack = 1'b1; mem_data = 8'h6B;
    @(posedge clk);
    #1;
    chk_all(100, 1'b1, 16'h0002, 8'h6B, 16'h0001, 1'b1, 1'b0);
    redirect = 1'b1; redirect_addr = 16'h4000; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk_all(101, 1'b1, 16'h0002, 8'hEA, 16'h4000, 1'b0, 1'b1);
    redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all(102, 1'b0, 16'h0000, 8'hEA, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_all(103, 1'b0, 16'h0000, 8'hEA, 16'h0000, 1'b0, 1'b0);
    mem_ack = 1'b1; mem_data = 8'hC3;
    @(posedge clk);
    #1;
    chk_all(104, 1'b1, 16'h0000, 8'hEA, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all(105, 1'b1, 16'h0001, 8'hC3, 16'h0000, 1'b1, 1'b0);
    mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
